// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (imem) and load/store (dmem); one transaction in flight, response routed to its owner.
// Optional MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT back-to-back dmem wins over a waiting imem, imem gets priority.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_req_valid,
  input  logic [ADDR_W-1:0] imem_req_addr,
  output logic              imem_req_ready,
  input  logic              imem_kill,
  output logic              imem_res_valid,
  output logic [DATA_W-1:0] imem_res_data,
  input  logic              dmem_req_valid,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic              dmem_req_fcn,
  input  logic [2:0]        dmem_req_typ,
  input  logic [DATA_W-1:0] dmem_req_data,
  output logic              dmem_req_ready,
  output logic              dmem_res_valid,
  output logic [DATA_W-1:0] dmem_res_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_fcn,
  output logic [2:0]        mem_req_typ,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_res_valid,
  input  logic [DATA_W-1:0] mem_res_data,
  output logic              protocol_err
);

  localparam logic       M_XRD = 1'b0;
  localparam logic [2:0] MT_W  = 3'd3;

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t fsm_q, fsm_d;
  logic   kill_q, kill_d;
  logic   err_q, err_d;
  logic   wr_q, wr_d;
  logic   imem_pri;
  logic   grant_imem, grant_dmem;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;

  assign imem_pri = (starve_q == CW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (imem_req_ready) begin
      starve_d = '0;
    end else if (dmem_req_ready) begin
      if (!imem_req_valid)
        starve_d = '0;
      else if (!imem_pri)
        starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign imem_pri = 1'b0;
`endif

  assign grant_dmem = dmem_req_valid && !(imem_pri && imem_req_valid);
  assign grant_imem = imem_req_valid && !grant_dmem;

  always_comb begin
    fsm_d          = fsm_q;
    kill_d         = kill_q;
    err_d          = err_q;
    wr_d           = wr_q;
    imem_req_ready = 1'b0;
    dmem_req_ready = 1'b0;
    imem_res_valid = 1'b0;
    imem_res_data  = '0;
    dmem_res_valid = 1'b0;
    dmem_res_data  = '0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_fcn    = M_XRD;
    mem_req_typ    = '0;
    mem_req_data   = '0;
    case (fsm_q)
      IDLE: begin
        // Gated by reset so every handshake output is quiet while reset is held.
        if (reset) begin
          mem_req_valid = grant_imem || grant_dmem;
          if (grant_dmem) begin
            mem_req_addr = dmem_req_addr;
            mem_req_fcn  = dmem_req_fcn;
            mem_req_typ  = dmem_req_typ;
            mem_req_data = dmem_req_data;
          end else if (grant_imem) begin
            mem_req_addr = imem_req_addr;
            mem_req_fcn  = M_XRD;
            mem_req_typ  = MT_W;
          end
          imem_req_ready = grant_imem && mem_req_ready;
          dmem_req_ready = grant_dmem && mem_req_ready;
          if (mem_res_valid) err_d = 1'b1;
          if (dmem_req_ready) begin
            fsm_d = WAIT_D;
            wr_d  = dmem_req_fcn;
          end else if (imem_req_ready) begin
            fsm_d  = WAIT_I;
            kill_d = imem_kill;
          end
        end
      end
      WAIT_I: begin
        if (mem_res_valid) begin
          imem_res_valid = !kill_q && !imem_kill;
          imem_res_data  = imem_res_valid ? mem_res_data : '0;
          fsm_d          = IDLE;
          kill_d         = 1'b0;
        end else if (imem_kill) begin
          kill_d = 1'b1;
        end
      end
      WAIT_D: begin
        if (mem_res_valid) begin
          dmem_res_valid = 1'b1;
          dmem_res_data  = wr_q ? '0 : mem_res_data;
          fsm_d          = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q  <= IDLE;
      kill_q <= 1'b0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      kill_q <= kill_d;
      err_q  <= err_d;
      wr_q   <= wr_d;
    end
  end

  assign protocol_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-owner model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic imem_req_valid, imem_kill, dmem_req_valid, dmem_req_fcn, mem_req_ready, mem_res_valid;
  logic [AW-1:0] imem_req_addr, dmem_req_addr;
  logic [2:0] dmem_req_typ;
  logic [DW-1:0] dmem_req_data, mem_res_data;
  logic imem_req_ready, imem_res_valid, dmem_req_ready, dmem_res_valid, mem_req_valid, mem_req_fcn, protocol_err;
  logic [DW-1:0] imem_res_data, dmem_res_data, mem_req_data;
  logic [AW-1:0] mem_req_addr;
  logic [2:0] mem_req_typ;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_kill(imem_kill), .imem_res_valid(imem_res_valid), .imem_res_data(imem_res_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr), .dmem_req_fcn(dmem_req_fcn),
    .dmem_req_typ(dmem_req_typ), .dmem_req_data(dmem_req_data), .dmem_req_ready(dmem_req_ready),
    .dmem_res_valid(dmem_res_valid), .dmem_res_data(dmem_res_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ), .mem_req_data(mem_req_data),
    .mem_res_valid(mem_res_valid), .mem_res_data(mem_res_data), .protocol_err(protocol_err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: who owns the port (0 none, 1 fetch, 2 data) and bookkeeping around it.
  int own = 0, m_starve = 0;
  bit m_kill = 0, m_wr = 0, m_err = 0, guard = 0;
  bit acc_i_q = 0, acc_d_q = 0;
  logic s_iv, s_dv, s_ir, s_dr, s_mv, s_err, s_fcn;
  logic [31:0] s_id, s_dd, s_addr;

  task automatic model_reset();
    own = 0; m_starve = 0; m_kill = 0; m_wr = 0; m_err = 0; acc_i_q = 0; acc_d_q = 0;
  endtask

  task automatic idle_inputs();
    imem_req_valid = 0; imem_req_addr = '0; imem_kill = 0;
    dmem_req_valid = 0; dmem_req_addr = '0; dmem_req_fcn = 0; dmem_req_typ = '0; dmem_req_data = '0;
    mem_req_ready = 0; mem_res_valid = 0; mem_res_data = '0;
  endtask

  // One clock: compare at negedge against the model, advance the model at posedge.
  task automatic cycle();
    bit idle, ipri, wi, wd, ai, ad, eiv, edv;
    @(negedge clk);
    idle = (own == 0);
    ipri = guard && (m_starve == LIM);
    wd   = idle && dmem_req_valid && !(ipri && imem_req_valid);
    wi   = idle && imem_req_valid && !wd;
    ai   = wi && mem_req_ready;
    ad   = wd && mem_req_ready;
    eiv  = (own == 1) && mem_res_valid && !m_kill && !imem_kill;
    edv  = (own == 2) && mem_res_valid;
    s_iv = imem_res_valid; s_dv = dmem_res_valid; s_ir = imem_req_ready; s_dr = dmem_req_ready;
    s_mv = mem_req_valid; s_err = protocol_err; s_fcn = mem_req_fcn;
    s_id = imem_res_data; s_dd = dmem_res_data; s_addr = mem_req_addr;
    check_eq("mem_req_valid", mem_req_valid, wi | wd);
    if (wd) begin
      check_eq("d_addr", mem_req_addr, dmem_req_addr);
      check_eq("d_fcn", mem_req_fcn, dmem_req_fcn);
      check_eq("d_typ", mem_req_typ, dmem_req_typ);
      check_eq("d_data", mem_req_data, dmem_req_data);
    end
    if (wi) begin
      check_eq("i_addr", mem_req_addr, imem_req_addr);
      check_eq("i_fcn", mem_req_fcn, 0);
      check_eq("i_typ", mem_req_typ, 3);
      check_eq("i_data", mem_req_data, 0);
    end
    check_eq("imem_req_ready", imem_req_ready, ai);
    check_eq("dmem_req_ready", dmem_req_ready, ad);
    check_eq("imem_res_valid", imem_res_valid, eiv);
    check_eq("imem_res_data", imem_res_data, eiv ? mem_res_data : 0);
    check_eq("dmem_res_valid", dmem_res_valid, edv);
    check_eq("dmem_res_data", dmem_res_data, (edv && !m_wr) ? mem_res_data : 0);
    check_eq("protocol_err", protocol_err, m_err);
    @(posedge clk);
    if (idle && mem_res_valid) m_err = 1;
    if (!idle && mem_res_valid) begin own = 0; m_kill = 0; end
    else if (own == 1 && imem_kill) m_kill = 1;
    if (ai) begin own = 1; m_kill = imem_kill; m_starve = 0; end
    if (ad) begin
      own = 2; m_wr = dmem_req_fcn;
      m_starve = imem_req_valid ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
    end
    acc_i_q = ai; acc_d_q = ad;
    #1;
  endtask

  int pulses, mcnt;
  string pat_got, pat_exp;

  initial begin
`ifdef MEM_ARB_STARVE_GUARD_EN
    guard = 1;
`endif
    idle_inputs();
    reset = 0;
    imem_req_valid = 1; dmem_req_valid = 1; mem_req_ready = 1;
    #1;
    check_eq("rst_mem_req_valid", mem_req_valid, 0);
    check_eq("rst_imem_req_ready", imem_req_ready, 0);
    check_eq("rst_dmem_req_ready", dmem_req_ready, 0);
    check_eq("rst_protocol_err", protocol_err, 0);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    model_reset();

    // Single fetch with a 3-cycle memory latency.
    imem_req_valid = 1; imem_req_addr = 32'h100; mem_req_ready = 1;
    cycle();
    check_eq("fetch_accept", s_ir, 1);
    check_eq("fetch_addr", s_addr, 32'h100);
    imem_req_valid = 0; pulses = 0;
    for (int i = 0; i < 3; i++) begin
      mem_res_valid = (i == 2); mem_res_data = 32'hDEADBEEF;
      cycle();
      pulses += int'(s_iv);
      check_eq("fetch_no_dres", s_dv, 0);
      if (i == 2) check_eq("fetch_data", s_id, 32'hDEADBEEF);
    end
    mem_res_valid = 0;
    cycle();
    pulses += int'(s_iv);
    check_eq("fetch_pulses", pulses, 1);

    // Simultaneous requests: dmem store goes first.
    imem_req_valid = 1; imem_req_addr = 32'h200;
    dmem_req_valid = 1; dmem_req_addr = 32'h40; dmem_req_fcn = 1; dmem_req_typ = 3'd3; dmem_req_data = 32'h55;
    cycle();
    check_eq("sim_dmem_first", s_dr, 1);
    check_eq("sim_fcn", s_fcn, 1);
    dmem_req_valid = 0; mem_res_valid = 1; mem_res_data = 32'hAAAA5555;
    cycle();
    check_eq("sim_wack", s_dv, 1);
    check_eq("sim_wack_data", s_dd, 0);
    check_eq("sim_no_imem_yet", s_ir, 0);
    mem_res_valid = 0;
    cycle();
    check_eq("sim_imem_next", s_ir, 1);
    check_eq("sim_imem_addr", s_addr, 32'h200);
    imem_req_valid = 0; mem_res_valid = 1; mem_res_data = 32'h0BADF00D;
    cycle();
    mem_res_valid = 0;

    // Kill one cycle after acceptance; the next fetch is serviced normally.
    imem_req_valid = 1; imem_req_addr = 32'h300;
    cycle();
    imem_req_valid = 0; imem_kill = 1;
    cycle();
    imem_kill = 0; mem_res_valid = 1; mem_res_data = 32'h12345678;
    cycle();
    check_eq("kill_suppressed", s_iv, 0);
    mem_res_valid = 0; imem_req_valid = 1; imem_req_addr = 32'h304;
    cycle();
    check_eq("kill_then_accept", s_ir, 1);
    imem_req_valid = 0; mem_res_valid = 1; mem_res_data = 32'hCAFE0001;
    cycle();
    check_eq("kill_next_resp", s_iv, 1);
    check_eq("kill_next_data", s_id, 32'hCAFE0001);
    mem_res_valid = 0;

    // Backpressure: imem waits, dmem appears in cycle 3 and wins.
    mem_req_ready = 0; imem_req_valid = 1; imem_req_addr = 32'h400;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        dmem_req_valid = 1; dmem_req_addr = 32'h80; dmem_req_fcn = 0; dmem_req_data = 32'h0;
      end
      cycle();
      check_eq("bp_imem_ready", s_ir, 0);
      if (i < 3) check_eq("bp_addr_stable", s_addr, 32'h400);
    end
    mem_req_ready = 1;
    cycle();
    check_eq("bp_dmem_wins", s_dr, 1);
    dmem_req_valid = 0; mem_res_valid = 1; mem_res_data = 32'h77778888;
    cycle();
    check_eq("bp_load_data", s_dd, 32'h77778888);
    mem_res_valid = 0;
    cycle();
    check_eq("bp_imem_after", s_ir, 1);
    imem_req_valid = 0; mem_res_valid = 1;
    cycle();
    mem_res_valid = 0;

    // Unsolicited response, then reset in the middle of a data transaction.
    mem_res_valid = 1; mem_res_data = 32'h1;
    cycle();
    mem_res_valid = 0;
    cycle();
    check_eq("err_set", s_err, 1);
    cycle();
    check_eq("err_sticky", s_err, 1);
    dmem_req_valid = 1; dmem_req_addr = 32'h90; dmem_req_fcn = 0;
    cycle();
    imem_req_valid = 1; mem_res_valid = 1;
    reset = 0;
    #1;
    check_eq("rst2_mem_req_valid", mem_req_valid, 0);
    check_eq("rst2_imem_req_ready", imem_req_ready, 0);
    check_eq("rst2_dmem_req_ready", dmem_req_ready, 0);
    check_eq("rst2_dmem_res_valid", dmem_res_valid, 0);
    check_eq("rst2_imem_res_valid", imem_res_valid, 0);
    check_eq("rst2_protocol_err", protocol_err, 0);
    idle_inputs();
    model_reset();
    @(negedge clk) reset = 1;
    @(posedge clk); #1;

    // Both requesters continuously valid: record the grant order.
    imem_req_valid = 1; imem_req_addr = 32'h500;
    dmem_req_valid = 1; dmem_req_addr = 32'h600; dmem_req_fcn = 0;
    mem_req_ready = 1;
    pat_got = ""; pat_exp = guard ? "DDDDIDDDDI" : "DDDDDDDDDD";
    for (int i = 0; i < 40 && pat_got.len() < 10; i++) begin
      mem_res_valid = (own != 0); mem_res_data = 32'(i);
      cycle();
      if (acc_i_q) pat_got = {pat_got, "I"};
      if (acc_d_q) pat_got = {pat_got, "D"};
    end
    check_eq("grant_count", pat_got.len(), 10);
    for (int i = 0; i < 10 && i < pat_got.len(); i++)
      check_eq($sformatf("grant_%0d", i), pat_got[i], pat_exp[i]);
    mem_res_valid = 1;
    cycle();
    idle_inputs();
    cycle();

    // Randomized traffic with holding requesters and a variable-latency memory.
    mcnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (acc_i_q || !imem_req_valid) begin
        imem_req_valid = ($urandom_range(0, 2) != 0);
        imem_req_addr  = $urandom;
      end
      if (acc_d_q || !dmem_req_valid) begin
        dmem_req_valid = ($urandom_range(0, 2) != 0);
        dmem_req_addr  = $urandom;
        dmem_req_fcn   = 1'($urandom_range(0, 1));
        dmem_req_typ   = 3'($urandom_range(1, 3));
        dmem_req_data  = $urandom;
      end
      imem_kill     = ($urandom_range(0, 5) == 0);
      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_res_valid = 0;
      if (own != 0) begin
        if (mcnt == 0) begin mem_res_valid = 1; mem_res_data = $urandom; end
        else mcnt--;
      end
      cycle();
      if (acc_i_q || acc_d_q) mcnt = $urandom_range(0, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
